// File: rtl/des_decrypt.sv
// Iterative DES decryption core: one Feistel round per clock, 16 rounds per block.
// Subkeys are produced on the fly by rotating the PC-1 halves right, starting from K16.
module des_decrypt (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:64] desIn,
  input  logic [1:64] keyIn,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:64] desOut,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

  localparam logic [6:0] IP_T [64] = '{
    58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
    57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
    61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};

  localparam logic [6:0] FP_T [64] = '{
    40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
    38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
    36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
    34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};

  localparam logic [6:0] E_T [48] = '{
    32,1,2,3,4,5,     4,5,6,7,8,9,       8,9,10,11,12,13,   12,13,14,15,16,17,
    16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};

  localparam logic [6:0] P_T [32] = '{
    16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
    2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};

  localparam logic [6:0] PC1_T [56] = '{
    57,49,41,33,25,17,9,  1,58,50,42,34,26,18,
    10,2,59,51,43,35,27,  19,11,3,60,52,44,36,
    63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
    14,6,61,53,45,37,29,  21,13,5,28,20,12,4};

  localparam logic [6:0] PC2_T [48] = '{
    14,17,11,24,1,5,   3,28,15,6,21,10,   23,19,12,4,26,8,   16,7,27,20,13,2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};

  localparam logic [3:0] SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  function automatic logic [1:64] perm64(input logic [1:64] x, input logic fp);
    logic [1:64] o;
    for (int unsigned i = 0; i < 64; i++)
      o[i+1] = fp ? x[FP_T[i]] : x[IP_T[i]];
    return o;
  endfunction

  function automatic logic [1:56] pc1(input logic [1:64] k);
    logic [1:56] o;
    for (int unsigned i = 0; i < 56; i++) o[i+1] = k[PC1_T[i]];
    return o;
  endfunction

  function automatic logic [1:48] pc2(input logic [1:56] cd);
    logic [1:48] o;
    for (int unsigned i = 0; i < 48; i++) o[i+1] = cd[PC2_T[i]];
    return o;
  endfunction

  function automatic logic [1:32] f_fn(input logic [1:32] r, input logic [1:48] k);
    logic [1:48] x;
    logic [1:32] s;
    logic [1:32] o;
    logic [1:6]  b;
    for (int unsigned i = 0; i < 48; i++) x[i+1] = r[E_T[i]];
    x = x ^ k;
    for (int unsigned j = 0; j < 8; j++) begin
      b = x[j*6+1 +: 6];
      s[j*4+1 +: 4] = SBOX[j][{b[1], b[6], b[2:5]}];
    end
    for (int unsigned i = 0; i < 32; i++) o[i+1] = s[P_T[i]];
    return o;
  endfunction

  state_t      r_state;
  logic [1:64] r_des;
  logic [1:28] r_c;
  logic [1:28] r_d;
  logic [3:0]  r_rnd;

  logic [1:32] w_f;
  logic [1:32] w_lx;
  logic [1:64] w_next;
  logic        w_rot1;
  logic [1:56] w_cd0;

  assign w_f    = f_fn(r_des[33:64], pc2({r_c, r_d}));
  assign w_lx   = r_des[1:32] ^ w_f;
  // Last round keeps the halves unswapped so FP can be applied directly.
  assign w_next = (r_rnd == 4'd15) ? {w_lx, r_des[33:64]} : {r_des[33:64], w_lx};
  assign w_rot1 = (r_rnd == 4'd0) || (r_rnd == 4'd7) || (r_rnd == 4'd14);
  assign w_cd0  = pc1(keyIn);

  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_ROUND);
  assign desOut    = perm64(r_des, 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_des   <= '0;
      r_c     <= '0;
      r_d     <= '0;
      r_rnd   <= '0;
    end else begin
      case (r_state)
        S_ROUND: begin
          r_des <= w_next;
          r_c   <= w_rot1 ? {r_c[28], r_c[1:27]} : {r_c[27:28], r_c[1:26]};
          r_d   <= w_rot1 ? {r_d[28], r_d[1:27]} : {r_d[27:28], r_d[1:26]};
          r_rnd <= r_rnd + 4'd1;
          if (r_rnd == 4'd15) r_state <= S_DONE;
        end
        default: begin
          // IDLE and DONE share the accept path; in_ready already qualifies DONE.
          if (in_valid && in_ready) begin
            r_des   <= perm64(desIn, 1'b0);
            r_c     <= w_cd0[1:28];
            r_d     <= w_cd0[29:56];
            r_rnd   <= '0;
            r_state <= S_ROUND;
          end else if (r_state == S_DONE && out_ready) begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_des_decrypt.sv
// Directed-vector bench for des_decrypt using known DES answers.
module tb_des_decrypt;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:64] desIn = '0;
  logic [1:64] keyIn = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:64] desOut;
  logic        busy;

  int checks = 0;
  int failures = 0;

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] C1 = 64'h85E813540F0AB405;
  localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] P2 = 64'h8787878787878787;
  localparam logic [63:0] PW = 64'h8CA64DE9C1B123A7;

  des_decrypt dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .desIn(desIn), .keyIn(keyIn), .out_valid(out_valid), .out_ready(out_ready),
    .desOut(desOut), .busy(busy)
  );

  always #5 clk = ~clk;

  // Called at a negedge; block is accepted on the next posedge.
  task automatic send(input logic [63:0] k, input logic [63:0] c);
    keyIn = k; desIn = c; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Negedges until out_valid is seen; -1 if the budget expires.
  task automatic wait_valid(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (out_valid) begin cyc = i; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      failures++; $display("FAIL reset_flags got=%b exp=100", {in_ready, out_valid, busy});
    end
    checks++;
    if (desOut !== 64'h0) begin failures++; $display("FAIL reset_desOut got=%h exp=0", desOut); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_known_answer;
    int cyc;
    out_ready = 1'b0;
    send(K1, C1);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      failures++; $display("FAIL kat_busy got busy=%b in_ready=%b exp 1 0", busy, in_ready);
    end
    wait_valid(cyc);
    cyc = (cyc < 0) ? cyc : cyc + 1;
    checks++;
    if (cyc !== 17) begin failures++; $display("FAIL kat_latency got=%0d exp=17", cyc); end
    checks++;
    if (desOut !== P1) begin failures++; $display("FAIL kat_data got=%h exp=%h", desOut, P1); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL kat_release got out_valid=%b in_ready=%b exp 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    out_ready = 1'b1;
    send(K2, 64'h0);
    wait_valid(cyc);
    checks++;
    if (desOut !== P2) begin failures++; $display("FAIL b2b_a_data got=%h exp=%h", desOut, P2); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
    keyIn = K1; desIn = C1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; keyIn = '0; desIn = '0;
    wait_valid(cyc);
    checks++;
    if (cyc !== 17) begin failures++; $display("FAIL b2b_b_latency got=%0d exp=17", cyc); end
    checks++;
    if (desOut !== P1) begin failures++; $display("FAIL b2b_b_data got=%h exp=%h", desOut, P1); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_b_once got=%b exp=0", out_valid); end
  endtask

  task automatic test_weak_key;
    int cyc;
    out_ready = 1'b1;
    send(64'h0101010101010101, 64'h0);
    wait_valid(cyc);
    checks++;
    if (cyc < 0 || desOut !== PW) begin
      failures++; $display("FAIL weak_key got=%h cyc=%0d exp=%h", desOut, cyc, PW);
    end
    @(negedge clk);
    send(64'h0, 64'h0);
    wait_valid(cyc);
    checks++;
    if (cyc < 0 || desOut !== PW) begin
      failures++; $display("FAIL parity_ignored got=%h cyc=%0d exp=%h", desOut, cyc, PW);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int cyc;
    int bad;
    out_ready = 1'b0;
    send(K1, C1);
    wait_valid(cyc);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; keyIn = K2; desIn = 64'h0;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || desOut !== P1) bad++;
      @(negedge clk);
    end
    checks++;
    if (cyc < 0 || bad != 0) begin
      failures++; $display("FAIL bp_stall got bad_cycles=%0d cyc=%0d exp 0", bad, cyc);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL bp_release got out_valid=%b in_ready=%b busy=%b exp 0 1 0",
                           out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    out_ready = 1'b1;
    send(K1, C1);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100 || desOut !== 64'h0) begin
      failures++; $display("FAIL rst_mid got flags=%b desOut=%h exp 100 0",
                           {in_ready, out_valid, busy}, desOut);
    end
    rst = 1'b1; in_valid = 1'b1; keyIn = K1; desIn = C1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_wins got busy=%b exp=0", busy); end
    send(K1, C1);
    wait_valid(cyc);
    checks++;
    if (cyc < 0 || desOut !== P1) begin
      failures++; $display("FAIL rst_recover got=%h cyc=%0d exp=%h", desOut, cyc, P1);
    end
    @(negedge clk);
  endtask

  task automatic test_ignored_input;
    int cyc;
    out_ready = 1'b1;
    send(K2, 64'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = i[0]; keyIn = K1 ^ 64'(i); desIn = C1 + 64'(i);
    end
    in_valid = 1'b0;
    wait_valid(cyc);
    cyc = (cyc < 0) ? cyc : cyc + 6;
    checks++;
    if (cyc !== 17 || desOut !== P2) begin
      failures++; $display("FAIL ignored_input got=%h cyc=%0d exp=%h cyc=17", desOut, cyc, P2);
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_known_answer();
    test_back_to_back();
    test_weak_key();
    test_backpressure();
    test_reset_mid();
    test_ignored_input();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/des_decrypt.md
# des_decrypt

Iterative DES decryption core: one Feistel round per clock, 16 rounds per block, with subkeys generated on the fly by right-rotating the PC-1 key halves. It is the inverse-direction companion of the iterative DES encryptor and reuses the same IP/FP, E, S-box, P and PC-1/PC-2 tables. Input and output use valid/ready handshakes, so the core can sit between a ciphertext source and a plaintext sink with back-pressure on both sides.

## Interface
- No parameters.
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ciphertext/key pair presented
- in_ready  out  1  core can accept a block this cycle
- desIn  in  64 [1:64]  ciphertext, bit 1 = MSB (DES bit numbering)
- keyIn  in  64 [1:64]  64-bit key including parity bits; parity bits are ignored
- out_valid  out  1  plaintext on desOut is valid
- out_ready  in  1  sink accepts plaintext
- desOut  out  64 [1:64]  plaintext = FP(final round register)
- busy  out  1  high while rounds are running (ROUND state)

## Operation
- State registers: des_reg[1:64] (L|R), C[1:28], D[1:28], round counter rnd[3:0], 2-bit state.
- States:
  - IDLE: in_ready=1. On in_valid: des_reg<=IP(desIn); {C,D}<=PC1(keyIn), with no rotation because C0/D0 equal C16/D16; rnd<=0; go to ROUND.
  - ROUND: subkey = PC2(C,D). Round r=rnd+1 uses K(17-r).
    - For rnd<15: des_reg<={R, L^f(R,subkey)}.
    - For rnd==15: des_reg<={L^f(R,subkey), R} (final swap omitted); go to DONE.
    - After each round, rotate C and D right by rot(rnd): rnd 0→1, 1–6→2, 7→1, 8–13→2, 14→1, 15→don't care (no rotation required).
    - rnd increments each cycle.
  - DONE: out_valid=1 and desOut is held stable.
    - On out_ready: if in_valid is also high, accept the new block exactly as in IDLE and go to ROUND; otherwise go to IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). desIn/keyIn are sampled only on an in_valid & in_ready edge and need not be held afterwards.
- desOut is combinational FP of des_reg. Outside DONE its value is don't-care for consumers but must not be X after reset.
- f function: E expansion 32→48, XOR subkey, S1–S8 (6→4 bits, row = bits 1 and 6, column = bits 2–5), P permutation.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, des_reg=0, C=D=0, rnd=0, desOut=FP(0)=0.
- Latency: accept at edge T; rounds on edges T+1..T+16; out_valid high in the cycle after edge T+16.
  - Minimum accept-to-accept spacing is 17 cycles, when out_ready is held high and in_valid is presented back-to-back.
- out_valid stays high until an out_ready edge. A stalled sink blocks new input (in_ready=0).
- in_valid during ROUND is ignored; no sampling, no effect.
- rst asserted in any state, including mid-round or in DONE with out_valid high, returns all registers to their reset values on that edge. The interrupted block is discarded and no out_valid pulse is produced.
- rst and in_valid together: rst wins and the block is not accepted.
- busy=1 exactly during the 16 ROUND cycles.

## Test plan
- Known answer: key 133457799BBCDFF1, desIn 85E813540F0AB405 → out_valid after 17 cycles, desOut 0123456789ABCDEF.
- Second vector and back-to-back: out_ready held high. Block A: key 0E329232EA6D0D73, desIn 0000000000000000 → 8787878787878787. Block B (first vector) is presented with in_valid in A's DONE cycle → B is accepted in that same cycle, out_valid for B 17 cycles later, and A's result is seen exactly one cycle.
- Weak key / parity ignored: key 0101010101010101 → desIn 0000000000000000 gives 8CA64DE9C1B123A7. Key 0000000000000000 must give the identical result, since only parity bits differ.
- Back-pressure: out_ready low for 10 cycles after out_valid rises → desOut stable, in_valid ignored with in_ready=0. Then out_ready=1 for one cycle → out_valid drops and in_ready=1.
- Reset mid-operation: rst at round 8 → next cycle state IDLE, out_valid=0, busy=0, desOut=0. A following known-answer block decrypts correctly.
- Ignored input: toggle desIn/keyIn and pulse in_valid during ROUND → result unchanged from the originally accepted block.
